i2c_txn_scheduler: RTL and testbench

//  Round-robin scheduler that shares one i2c_master between NUM_REQ requesters
//  (e.g. ALEX filters, PA bias, tuner, telemetry). It latches the winner's

---
 rtl/i2c_txn_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_i2c_txn_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler sharing one i2c_master between NUM_REQ requesters.
// Latches the winner's request, drives ena/busy, enforces bus-free gap and a per-transaction timeout.
module i2c_txn_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int GAP_CYC = 16,
    parameter int TO_CYC  = 1024
) (
    input  logic                    I2C_clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [7*NUM_REQ-1:0]    req_addr_i,
    input  logic [NUM_REQ-1:0]      req_rw_i,
    input  logic [16*NUM_REQ-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]      done_o,
    output logic [15:0]             rsp_data_o,
    output logic                    rsp_err_o,
    output logic                    m_ena_o,
    output logic [6:0]              m_addr_o,
    output logic                    m_rw_o,
    output logic [15:0]             m_data_wr_o,
    input  logic                    m_busy_i,
    input  logic [15:0]             m_data_rd_i,
    input  logic                    m_ack_error_i,
    output logic [1:0]              state_o
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAPW = $clog2(GAP_CYC + 1);
    localparam int TOW  = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [GAPW-1:0]    gap_q, gap_d;
    logic [TOW-1:0]     to_q, to_d;
    logic [IDXW-1:0]    rr_q, rr_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [6:0]         addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [15:0]        wr_q, wr_d;
    logic               ena_q, ena_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [15:0]        rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic               win_found;
    logic [IDXW-1:0]    win_idx;
    logic [IDXW:0]      cand;
    logic [6:0]         win_addr;
    logic               win_rw;
    logic [15:0]        win_data;
    logic               fin, fin_timeout;

    // Search upward from rr_q with wrap; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (IDXW+1)'(k);
            if (cand >= (IDXW+1)'(NUM_REQ)) begin
                cand = cand - (IDXW+1)'(NUM_REQ);
            end
            if (!win_found && req_i[cand[IDXW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDXW-1:0];
            end
        end
        win_addr = '0;
        win_rw   = 1'b0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDXW'(i)) begin
                win_addr = req_addr_i[7*i +: 7];
                win_rw   = req_rw_i[i];
                win_data = req_data_i[16*i +: 16];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        to_d        = to_q;
        rr_d        = rr_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        wr_d        = wr_q;
        ena_d       = 1'b0;
        done_d      = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        fin         = 1'b0;
        fin_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (gap_q != GAPW'(GAP_CYC)) begin
                    gap_d = gap_q + 1'b1;
                end
                if (gap_q == GAPW'(GAP_CYC) && !m_busy_i && win_found) begin
                    state_d = S_ISSUE;
                    idx_d   = win_idx;
                    addr_d  = win_addr;
                    rw_d    = win_rw;
                    wr_d    = win_data;
                    to_d    = '0;
                    ena_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                to_d  = to_q + 1'b1;
                ena_d = 1'b1;
                if (to_q == TOW'(TO_CYC - 1)) begin
                    ena_d       = 1'b0;
                    state_d     = S_DONE;
                    fin         = 1'b1;
                    fin_timeout = 1'b1;
                end else if (m_busy_i) begin
                    ena_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                to_d = to_q + 1'b1;
                if (to_q == TOW'(TO_CYC - 1)) begin
                    state_d     = S_DONE;
                    gap_d       = '0;
                    fin         = 1'b1;
                    fin_timeout = 1'b1;
                end else if (!m_busy_i) begin
                    state_d = S_DONE;
                    gap_d   = '0;
                    fin     = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                rr_d    = (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // done and response are registered on entry to DONE so they line up with that state.
        if (fin) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                done_d[i] = (idx_q == IDXW'(i));
            end
            rsp_data_d = fin_timeout ? 16'h0000 : m_data_rd_i;
            rsp_err_d  = fin_timeout ? 1'b1 : m_ack_error_i;
        end
    end

    always_ff @(posedge I2C_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            gap_q      <= GAPW'(GAP_CYC);
            to_q       <= '0;
            rr_q       <= '0;
            idx_q      <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            wr_q       <= '0;
            ena_q      <= 1'b0;
            done_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            to_q       <= to_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            wr_q       <= wr_d;
            ena_q      <= ena_d;
            done_q     <= done_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign done_o      = done_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign m_ena_o     = ena_q;
    assign m_addr_o    = addr_q;
    assign m_rw_o      = rw_q;
    assign m_data_wr_o = wr_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Bench for i2c_txn_scheduler: i2c_master behavioural model, requester tasks,
// expected-queue scoreboard popped on every done pulse.
module tb_i2c_txn_scheduler;

    localparam int NUM_REQ = 4;
    localparam int GAP_CYC = 16;
    localparam int TO_CYC  = 1024;
    localparam int EW      = 45;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req_i;
    logic [7*NUM_REQ-1:0]  req_addr_i;
    logic [NUM_REQ-1:0]    req_rw_i;
    logic [16*NUM_REQ-1:0] req_data_i;
    logic [NUM_REQ-1:0]    done_o;
    logic [15:0]           rsp_data_o;
    logic                  rsp_err_o;
    logic                  m_ena_o;
    logic [6:0]            m_addr_o;
    logic                  m_rw_o;
    logic [15:0]           m_data_wr_o;
    logic                  m_busy;
    logic [15:0]           m_data_rd;
    logic                  m_ack_error;
    logic [1:0]            state_o;

    int tests_run = 0;
    int tests_failed = 0;

    // {done[3:0], rsp_data[15:0], rsp_err, m_addr[6:0], m_rw, m_data_wr[15:0]}
    logic [EW-1:0] exp_q[$];

    i2c_txn_scheduler #(.NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)) dut (
        .I2C_clock    (clk),
        .reset_n      (reset_n),
        .req_i        (req_i),
        .req_addr_i   (req_addr_i),
        .req_rw_i     (req_rw_i),
        .req_data_i   (req_data_i),
        .done_o       (done_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .m_ena_o      (m_ena_o),
        .m_addr_o     (m_addr_o),
        .m_rw_o       (m_rw_o),
        .m_data_wr_o  (m_data_wr_o),
        .m_busy_i     (m_busy),
        .m_data_rd_i  (m_data_rd),
        .m_ack_error_i(m_ack_error),
        .state_o      (state_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] mk_exp(input int idx, input logic [15:0] rd, input logic err,
                                             input logic [6:0] a, input logic rw, input logic [15:0] wr);
        logic [3:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return {oh, rd, err, a, rw, wr};
    endfunction

    // ---------------- i2c_master model ----------------
    int          busy_len = 40;
    logic        hang = 1'b0;
    logic [15:0] model_rd = 16'h0000;
    logic        model_nack = 1'b0;
    int          phase = 0;
    int          busy_cnt = 0;

    initial begin
        m_busy = 1'b0;
        m_data_rd = '0;
        m_ack_error = 1'b0;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 4;
            if (m_busy) begin
                if (!hang) begin
                    if (busy_cnt > 0) busy_cnt--;
                    if (busy_cnt == 0) m_busy = 1'b0;
                end
            end else if (phase == 0 && m_ena_o) begin
                m_busy      = 1'b1;
                busy_cnt    = busy_len;
                m_data_rd   = model_rd;
                m_ack_error = model_nack;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        prev_ena = 1'b0;
    logic [1:0]  prev_state = 2'd0;
    logic [3:0]  prev_done = 4'd0;
    int          ena_cyc = 0, ena_len = 0, fall_cyc = 0, ena_rises = 0;
    bit          armed = 1'b0;
    bit          to_expect = 1'b0;
    logic [6:0]  cap_addr;
    logic        cap_rw;
    logic [15:0] cap_wr;

    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                prev_ena = 1'b0;
                prev_done = '0;
                prev_state = 2'd0;
                armed = 1'b0;
            end else begin
                if (m_ena_o && !prev_ena) begin
                    ena_cyc = cyc;
                    ena_len = 0;
                    ena_rises++;
                    cap_addr = m_addr_o;
                    cap_rw = m_rw_o;
                    cap_wr = m_data_wr_o;
                    if (armed) begin
                        check("gap_cycles", 64'((cyc - fall_cyc) >= GAP_CYC), 64'd1);
                        armed = 1'b0;
                    end
                end
                if (m_ena_o && prev_ena) begin
                    check("m_addr_stable", m_addr_o, cap_addr);
                    check("m_data_wr_stable", m_data_wr_o, cap_wr);
                    check("m_rw_stable", m_rw_o, cap_rw);
                end
                if (m_ena_o) ena_len++;
                if (!m_ena_o && prev_ena) check("ena_len_le5", 64'(ena_len <= 5), 64'd1);
                if (prev_state == 2'd2 && state_o == 2'd3 && !m_busy) begin
                    fall_cyc = cyc;
                    armed = 1'b1;
                end
                if (done_o != '0) begin
                    check("done_1cyc", prev_done, 64'd0);
                    check("done_in_done_state", state_o, 64'd3);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", done_o, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_vec", done_o, e[44:41]);
                        check("rsp_data", rsp_data_o, e[40:25]);
                        check("rsp_err", rsp_err_o, e[24]);
                        check("m_addr", m_addr_o, e[23:17]);
                        check("m_rw", m_rw_o, e[16]);
                        check("m_data_wr", m_data_wr_o, e[15:0]);
                        if (to_expect) begin
                            check("timeout_cycles", 64'(cyc - ena_cyc), 64'(TO_CYC));
                            to_expect = 1'b0;
                        end
                    end
                end
                prev_ena = m_ena_o;
                prev_done = done_o;
                prev_state = state_o;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_req(input int i, input logic [6:0] a, input logic rw, input logic [15:0] d);
        bit got;
        req_addr_i[7*i +: 7]   = a;
        req_rw_i[i]            = rw;
        req_data_i[16*i +: 16] = d;
        req_i[i]               = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 4000 && !got; n++) begin
            @(posedge clk);
            #3;
            if (done_o[i]) got = 1'b1;
        end
        if (!got) check($sformatf("done_wait_req%0d", i), 64'd0, 64'd1);
        req_i[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_done"}, done_o, 64'd0);
        check({pfx, "_rsp_data"}, rsp_data_o, 64'd0);
        check({pfx, "_rsp_err"}, rsp_err_o, 64'd0);
        check({pfx, "_m_ena"}, m_ena_o, 64'd0);
        check({pfx, "_m_addr"}, m_addr_o, 64'd0);
        check({pfx, "_m_rw"}, m_rw_o, 64'd0);
        check({pfx, "_m_data_wr"}, m_data_wr_o, 64'd0);
        check({pfx, "_state"}, state_o, 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int rises_before;
        bit seen_wait;
        reset_n    = 1'b0;
        req_i      = '0;
        req_addr_i = '0;
        req_rw_i   = '0;
        req_data_i = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // single write; requester scribbles its inputs after grant
        model_rd = 16'hBEEF;
        exp_q.push_back(mk_exp(0, 16'hBEEF, 1'b0, 7'h20, 1'b0, 16'hA55A));
        fork
            run_req(0, 7'h20, 1'b0, 16'hA55A);
            begin
                for (int n = 0; n < 300 && !m_ena_o; n++) @(negedge clk);
                req_addr_i[6:0]  = 7'h7F;
                req_data_i[15:0] = 16'h0F0F;
            end
        join

        // read
        model_rd = 16'h1234;
        exp_q.push_back(mk_exp(2, 16'h1234, 1'b0, 7'h51, 1'b1, 16'h0000));
        run_req(2, 7'h51, 1'b1, 16'h0000);

        // all four held from a fresh pointer: order 0,1,2,3,0
        do_reset();
        model_rd = 16'h5A5A;
        exp_q.push_back(mk_exp(0, 16'h5A5A, 1'b0, 7'h10, 1'b0, 16'h1111));
        exp_q.push_back(mk_exp(1, 16'h5A5A, 1'b0, 7'h11, 1'b1, 16'h2222));
        exp_q.push_back(mk_exp(2, 16'h5A5A, 1'b0, 7'h12, 1'b0, 16'h3333));
        exp_q.push_back(mk_exp(3, 16'h5A5A, 1'b0, 7'h13, 1'b1, 16'h4444));
        exp_q.push_back(mk_exp(0, 16'h5A5A, 1'b0, 7'h14, 1'b0, 16'h5555));
        fork
            begin
                run_req(0, 7'h10, 1'b0, 16'h1111);
                run_req(0, 7'h14, 1'b0, 16'h5555);
            end
            run_req(1, 7'h11, 1'b1, 16'h2222);
            run_req(2, 7'h12, 1'b0, 16'h3333);
            run_req(3, 7'h13, 1'b1, 16'h4444);
        join

        // NACK, then a clean transaction
        model_rd = 16'h00C3;
        model_nack = 1'b1;
        exp_q.push_back(mk_exp(1, 16'h00C3, 1'b1, 7'h3C, 1'b0, 16'hDEAD));
        run_req(1, 7'h3C, 1'b0, 16'hDEAD);
        model_nack = 1'b0;
        model_rd = 16'h0A0B;
        exp_q.push_back(mk_exp(1, 16'h0A0B, 1'b0, 7'h3D, 1'b1, 16'hBEAD));
        run_req(1, 7'h3D, 1'b1, 16'hBEAD);

        // timeout: master stuck busy
        hang = 1'b1;
        model_rd = 16'h9999;
        to_expect = 1'b1;
        exp_q.push_back(mk_exp(1, 16'h0000, 1'b1, 7'h33, 1'b0, 16'hC0DE));
        run_req(1, 7'h33, 1'b0, 16'hC0DE);
        rises_before = ena_rises;
        exp_q.push_back(mk_exp(2, 16'h9999, 1'b0, 7'h44, 1'b0, 16'h4242));
        fork
            run_req(2, 7'h44, 1'b0, 16'h4242);
            begin
                repeat (200) @(negedge clk);
                check("no_ena_while_busy", ena_rises, rises_before);
                hang = 1'b0;
            end
        join

        // reset during WAIT: no done, held request granted again afterwards
        model_rd = 16'h7777;
        exp_q.push_back(mk_exp(3, 16'h7777, 1'b0, 7'h2A, 1'b1, 16'h0000));
        fork
            run_req(3, 7'h2A, 1'b1, 16'h0000);
            begin
                seen_wait = 1'b0;
                for (int n = 0; n < 300 && !seen_wait; n++) begin
                    @(negedge clk);
                    if (state_o == 2'd2) seen_wait = 1'b1;
                end
                check("reached_wait", seen_wait, 64'd1);
                reset_n = 1'b0;
                #1;
                check_outputs_zero("midreset");
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
            end
        join

        repeat (20) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
